multi_channel_filtered_synchronizer: RTL and testbench



---
 rtl/multi_channel_filtered_synchronizer.sv | 85 ++++++++
 tb/tb_multi_channel_filtered_synchronizer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_filtered_synchronizer.sv
// Per-bit synchroniser chain with an optional persistence filter and one-cycle
// rise/fall pulses derived from the filtered level.
module multi_channel_filtered_synchronizer #(
   parameter int                  CHANNELS      = 4,
   parameter int                  STAGES        = 3,
   parameter int                  FILTER_CYCLES = 0,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);
   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

   generate
      if (STAGES < 2) begin : g_bad_stages
         $error("multi_channel_filtered_synchronizer: STAGES must be at least 2");
      end
   endgenerate

   logic [CHANNELS-1:0] sync_level;
   logic [CHANNELS-1:0] prev_reg;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         // Bit 0 captures the asynchronous input; only the last bit is consumed.
         (* ASYNC_REG = "TRUE", dont_touch = "true" *)
         logic [STAGES-1:0] chain_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               chain_reg <= {STAGES{RESET_VALUE[gi]}};
            end else if (enable) begin
               chain_reg <= {chain_reg[STAGES-2:0], in[gi]};
            end
         end

         assign sync_level[gi] = chain_reg[STAGES-1];

         if (FILTER_CYCLES == 0) begin : g_nofilt
            assign out[gi] = sync_level[gi];
         end else begin : g_filt
            logic [CNT_W-1:0] cnt_reg;
            logic             out_reg;

            // A changed level must be seen on FILTER_CYCLES consecutive enabled edges.
            always_ff @(posedge clk) begin
               if (rst) begin
                  cnt_reg <= '0;
                  out_reg <= RESET_VALUE[gi];
               end else if (enable) begin
                  if (sync_level[gi] == out_reg) begin
                     cnt_reg <= '0;
                  end else if (cnt_reg == CNT_W'(FILTER_CYCLES - 1)) begin
                     out_reg <= sync_level[gi];
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
            end

            assign out[gi] = out_reg;
         end
      end
   endgenerate

   // prev ignores enable so a pulse always clears after exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg <= RESET_VALUE;
      end else begin
         prev_reg <= out;
      end
   end

   assign rise = out & ~prev_reg;
   assign fall = ~out & prev_reg;

endmodule

// File: tb/tb_multi_channel_filtered_synchronizer.sv
// Drives five differently configured synchronisers from shared stimulus and
// compares each against a window-based reference model every cycle.
module tb_multi_channel_filtered_synchronizer;
   localparam int NI = 5;

   function automatic int st_of(input int i);
      case (i)
         1:       return 2;
         2:       return 5;
         default: return 3;
      endcase
   endfunction

   function automatic int fc_of(input int i);
      return (i >= 3) ? 4 : 0;
   endfunction

   function automatic logic [3:0] rv_of(input int i);
      return (i == 4) ? 4'b1010 : 4'b0000;
   endfunction

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic [3:0] in_v = 4'b0000;
   logic       checking = 1'b0;
   logic [3:0] out_w  [NI];
   logic [3:0] rise_w [NI];
   logic [3:0] fall_w [NI];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_inst
         localparam int         ST = st_of(gi);
         localparam int         FC = fc_of(gi);
         localparam logic [3:0] RV = rv_of(gi);

         multi_channel_filtered_synchronizer #(
            .CHANNELS     (4),
            .STAGES       (ST),
            .FILTER_CYCLES(FC),
            .RESET_VALUE  (RV)
         ) dut (
            .clk   (clk),
            .rst   (rst),
            .enable(enable),
            .in    (in_v),
            .out   (out_w[gi]),
            .rise  (rise_w[gi]),
            .fall  (fall_w[gi])
         );

         // hist: input samples on enabled edges, newest first.
         // shist: synchronised samples seen by the filter since reset, newest first.
         logic [3:0] hist  [$];
         logic [3:0] shist [$];
         logic [3:0] m_out;
         logic [3:0] m_prev;

         always @(posedge clk) begin
            logic [3:0] sync_old;
            logic [3:0] nxt;
            bit         all_diff;
            if (rst) begin
               hist = {};
               for (int k = 0; k < ST; k++) hist.push_front(RV);
               shist = {};
               m_out = RV;
               m_prev = RV;
            end else begin
               m_prev = m_out;
               if (enable) begin
                  sync_old = hist[ST-1];
                  hist.push_front(in_v);
                  void'(hist.pop_back());
                  if (FC == 0) begin
                     m_out = hist[ST-1];
                  end else begin
                     shist.push_front(sync_old);
                     if (shist.size() > FC) void'(shist.pop_back());
                     nxt = m_out;
                     if (shist.size() == FC) begin
                        for (int ch = 0; ch < 4; ch++) begin
                           all_diff = 1'b1;
                           for (int k = 0; k < FC; k++)
                              if (shist[k][ch] == m_out[ch]) all_diff = 1'b0;
                           if (all_diff) nxt[ch] = ~m_out[ch];
                        end
                     end
                     m_out = nxt;
                  end
               end
            end
         end

         always @(negedge clk) begin
            if (checking) begin
               checks++;
               if (out_w[gi] !== m_out || rise_w[gi] !== (m_out & ~m_prev) ||
                   fall_w[gi] !== (~m_out & m_prev)) begin
                  errors++;
                  $display("FAIL model_dut%0d t=%0t out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                           gi, $time, out_w[gi], rise_w[gi], fall_w[gi],
                           m_out, m_out & ~m_prev, ~m_out & m_prev);
               end
            end
         end
      end
   endgenerate

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%b required=%b", name, $time, act, exp);
      end else begin
         $display("check %s t=%0t value=%b", name, $time, act);
      end
   endtask

   initial begin
      step(2);
      rst = 1'b0;
      checking = 1'b1;
      chk("reset_out0", out_w[0], 4'b0000);
      chk("reset_rise0", rise_w[0], 4'b0000);
      chk("reset_out4", out_w[4], 4'b1010);
      chk("reset_fall4", fall_w[4], 4'b0000);

      // Basic latency on channel 0
      in_v = 4'b0001;
      step(2); chk("lat_out0_early", out_w[0], 4'b0000);
      step(1); chk("lat_out0", out_w[0], 4'b0001);
      chk("lat_rise0", rise_w[0], 4'b0001);
      step(1); chk("lat_rise0_clear", rise_w[0], 4'b0000);
      step(15);

      // Depth sweep on channel 2
      in_v = 4'b0101;
      step(1); chk("depth2_early", out_w[1], 4'b0001);
      step(1); chk("depth2_out", out_w[1], 4'b0101);
      chk("depth2_rise", rise_w[1], 4'b0100);
      step(2); chk("depth5_early", out_w[2], 4'b0001);
      step(1); chk("depth5_out", out_w[2], 4'b0101);
      chk("depth5_rise", rise_w[2], 4'b0100);
      step(10);
      in_v = 4'b0001;
      step(2); chk("depth2_fall", fall_w[1], 4'b0100);
      chk("depth2_fall_out", out_w[1], 4'b0001);
      step(3); chk("depth5_fall", fall_w[2], 4'b0100);
      step(10);

      // Glitch filter on channel 1
      in_v = 4'b0011;
      step(3);
      in_v = 4'b0001;
      step(12); chk("glitch_blocked", out_w[3], 4'b0001);
      in_v = 4'b0011;
      step(6); chk("filt_early", out_w[3], 4'b0001);
      in_v = 4'b0001;
      step(1); chk("filt_out", out_w[3], 4'b0011);
      chk("filt_rise", rise_w[3], 4'b0010);
      step(5); chk("filt_fall_early", fall_w[3], 4'b0000);
      step(1); chk("filt_fall", fall_w[3], 4'b0010);
      chk("filt_fall_out", out_w[3], 4'b0001);
      step(10);

      // Enable gating mid-propagation on channel 3
      in_v = 4'b1001;
      step(1);
      enable = 1'b0;
      step(10); chk("gate_frozen", out_w[0], 4'b0001);
      enable = 1'b1;
      step(1); chk("gate_resume_early", out_w[0], 4'b0001);
      step(1); chk("gate_resume_out", out_w[0], 4'b1001);
      chk("gate_resume_rise", rise_w[0], 4'b1000);
      enable = 1'b0;
      step(1); chk("gate_pulse_width", rise_w[0], 4'b0000);
      chk("gate_hold_out", out_w[0], 4'b1001);
      enable = 1'b1;
      step(15);

      // Reset with a non-zero reset value, then reset in the middle of a filter count
      in_v = 4'b1010;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rv_out", out_w[4], 4'b1010);
      chk("rv_rise", rise_w[4], 4'b0000);
      chk("rv_fall", fall_w[4], 4'b0000);
      step(5);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(6); chk("midcount_early", out_w[3], 4'b0000);
      step(1); chk("midcount_out", out_w[3], 4'b1010);
      chk("midcount_rise", rise_w[3], 4'b1010);

      // Simultaneous channels
      in_v = 4'b0000;
      step(20);
      in_v = 4'b1111;
      step(2); chk("simul_early", rise_w[0], 4'b0000);
      step(1); chk("simul_rise", rise_w[0], 4'b1111);
      chk("simul_out", out_w[0], 4'b1111);
      step(1); chk("simul_rise_clear", rise_w[0], 4'b0000);
      step(10);
      in_v = 4'b0101;
      step(3); chk("simul_fall", fall_w[0], 4'b1010);
      chk("simul_fall_rise", rise_w[0], 4'b0000);
      step(10);

      // Mixed traffic checked against the model only
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) in_v = 4'($urandom);
         enable = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 99) == 0);
         step(1);
      end
      rst = 1'b0;
      enable = 1'b1;
      step(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
